// File: rtl/jedro_1_mem_arbiter.sv
// Two-requester arbiter (IFU read-only, LSU read/write) sharing one single-port RAM.
// One access granted per cycle; read data returns one cycle later to the issuing port.
module jedro_1_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ARB_MODE   = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ifu_req_i,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr_i,
  output logic                    ifu_gnt_o,
  output logic                    ifu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ifu_rdata_o,
  input  logic                    lsu_req_i,
  input  logic                    lsu_we_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_be_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  output logic                    lsu_gnt_o,
  output logic                    lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic                    mem_en_o,
  output logic [DATA_WIDTH/8-1:0] mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic [1:0]              dbg_resp_owner_o  // 0 = NONE, 1 = IFU, 2 = LSU
);

  // Handshake: a requester holds req/addr/wdata stable until its gnt is high in the
  // same cycle; the access is taken at that clock edge and read data is valid (rvalid)
  // exactly one cycle later. No backpressure exists on the response side.

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_e;

  owner_e                resp_owner;
  logic                  rr_last_lsu;
  logic [DATA_WIDTH-1:0] ifu_hold;
  logic [DATA_WIDTH-1:0] lsu_hold;

  // On conflict, round-robin favours whoever did not win last; fixed mode favours LSU.
  always_comb begin
    ifu_gnt_o = 1'b0;
    lsu_gnt_o = 1'b0;
    if (!rst_i) begin
      if (ifu_req_i && lsu_req_i) begin
        if ((ARB_MODE != 0) || !rr_last_lsu) lsu_gnt_o = 1'b1;
        else                                 ifu_gnt_o = 1'b1;
      end else begin
        ifu_gnt_o = ifu_req_i;
        lsu_gnt_o = lsu_req_i;
      end
    end
  end

  always_comb begin
    mem_en_o    = ifu_gnt_o | lsu_gnt_o;
    mem_we_o    = (lsu_gnt_o && lsu_we_i) ? lsu_be_i : '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (lsu_gnt_o) begin
      mem_addr_o  = lsu_addr_i;
      mem_wdata_o = lsu_wdata_i;
    end else if (ifu_gnt_o) begin
      mem_addr_o  = ifu_addr_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_owner  <= OWN_NONE;
      rr_last_lsu <= 1'b1;
      ifu_hold    <= '0;
      lsu_hold    <= '0;
    end else begin
      if (resp_owner == OWN_IFU) ifu_hold <= mem_rdata_i;
      if (resp_owner == OWN_LSU) lsu_hold <= mem_rdata_i;
      if (ifu_gnt_o) begin
        resp_owner  <= OWN_IFU;
        rr_last_lsu <= 1'b0;
      end else if (lsu_gnt_o) begin
        // Writes finish at the grant edge and never produce a response.
        resp_owner  <= lsu_we_i ? OWN_NONE : OWN_LSU;
        rr_last_lsu <= 1'b1;
      end else begin
        resp_owner  <= OWN_NONE;
      end
    end
  end

  assign ifu_rvalid_o     = (resp_owner == OWN_IFU);
  assign lsu_rvalid_o     = (resp_owner == OWN_LSU);
  assign ifu_rdata_o      = ifu_rvalid_o ? mem_rdata_i : ifu_hold;
  assign lsu_rdata_o      = lsu_rvalid_o ? mem_rdata_i : lsu_hold;
  assign dbg_resp_owner_o = resp_owner;

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Bench for jedro_1_mem_arbiter: round-robin instance with a RAM model, plus a
// fixed-priority instance sharing the same request inputs.
module tb_jedro_1_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [3:0]  lsu_be = '0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;

  logic        ifu_gnt0, ifu_rvalid0, lsu_gnt0, lsu_rvalid0, mem_en0;
  logic [31:0] ifu_rdata0, lsu_rdata0, mem_addr0, mem_wdata0;
  logic [31:0] mem_rdata0 = '0;
  logic [3:0]  mem_we0;
  logic [1:0]  dbg0;

  logic        ifu_gnt1, ifu_rvalid1, lsu_gnt1, lsu_rvalid1, mem_en1;
  logic [31:0] ifu_rdata1, lsu_rdata1, mem_addr1, mem_wdata1;
  logic [3:0]  mem_we1;
  logic [1:0]  dbg1;

  int tests_run = 0;
  int tests_failed = 0;

  // Clock / reset
  always #5 clk = ~clk;

  jedro_1_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ARB_MODE(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr), .ifu_gnt_o(ifu_gnt0),
    .ifu_rvalid_o(ifu_rvalid0), .ifu_rdata_o(ifu_rdata0),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be), .lsu_addr_i(lsu_addr),
    .lsu_wdata_i(lsu_wdata), .lsu_gnt_o(lsu_gnt0), .lsu_rvalid_o(lsu_rvalid0),
    .lsu_rdata_o(lsu_rdata0),
    .mem_en_o(mem_en0), .mem_we_o(mem_we0), .mem_addr_o(mem_addr0),
    .mem_wdata_o(mem_wdata0), .mem_rdata_i(mem_rdata0), .dbg_resp_owner_o(dbg0)
  );

  jedro_1_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ARB_MODE(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr), .ifu_gnt_o(ifu_gnt1),
    .ifu_rvalid_o(ifu_rvalid1), .ifu_rdata_o(ifu_rdata1),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be), .lsu_addr_i(lsu_addr),
    .lsu_wdata_i(lsu_wdata), .lsu_gnt_o(lsu_gnt1), .lsu_rvalid_o(lsu_rvalid1),
    .lsu_rdata_o(lsu_rdata1),
    .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
    .mem_wdata_o(mem_wdata1), .mem_rdata_i(32'h0), .dbg_resp_owner_o(dbg1)
  );

  // RAM model behind dut0: byte-enable writes, one-cycle read latency.
  logic [31:0] ram [256];
  logic        ram_init = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    return 32'h13 + 32'(i) * 32'h100;
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (mem_en0) begin
      if (mem_we0 != 4'b0) begin
        for (int b = 0; b < 4; b++)
          if (mem_we0[b]) ram[mem_addr0[9:2]][8*b +: 8] <= mem_wdata0[8*b +: 8];
      end else begin
        mem_rdata0 <= ram[mem_addr0[9:2]];
      end
    end
  end

  // Reference model: shadow memory, who won last, which port gets the next response.
  logic [31:0] shadow [256];
  logic        m_rr_lsu;
  int          m_owner;    // 0 none, 1 ifu, 2 lsu
  logic [31:0] m_word;
  logic [31:0] m_ifu_hold, m_lsu_hold;
  int          m1_owner;
  int          ifu_wait, lsu_wait;
  logic        last_gi, last_gl;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: one clock of stimulus, checked mid-cycle, model advanced after the edge.
  task automatic cycle(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                       input logic [3:0] lb, input logic [31:0] la, input logic [31:0] ld);
    logic e_gi, e_gl, e1_gi, e1_gl;
    rst = 1'b0;
    ifu_req = ir; ifu_addr = ia;
    lsu_req = lr; lsu_we = lw; lsu_be = lb; lsu_addr = la; lsu_wdata = ld;
    #3;
    e_gi  = ir && (!lr || m_rr_lsu);
    e_gl  = lr && (!ir || !m_rr_lsu);
    e1_gl = lr;
    e1_gi = ir && !lr;
    chk("ifu_gnt", 32'(ifu_gnt0), 32'(e_gi));
    chk("lsu_gnt", 32'(lsu_gnt0), 32'(e_gl));
    chk("mem_en", 32'(mem_en0), 32'(e_gi | e_gl));
    chk("mem_we", 32'(mem_we0), (e_gl && lw) ? 32'(lb) : 32'h0);
    chk("mem_addr", mem_addr0, e_gl ? la : (e_gi ? ia : 32'h0));
    if (e_gl && lw) chk("mem_wdata", mem_wdata0, ld);
    chk("ifu_rvalid", 32'(ifu_rvalid0), 32'(m_owner == 1));
    chk("lsu_rvalid", 32'(lsu_rvalid0), 32'(m_owner == 2));
    chk("ifu_rdata", ifu_rdata0, (m_owner == 1) ? m_word : m_ifu_hold);
    chk("lsu_rdata", lsu_rdata0, (m_owner == 2) ? m_word : m_lsu_hold);
    chk("dbg_owner", 32'(dbg0), 32'(m_owner));
    chk("fp_ifu_gnt", 32'(ifu_gnt1), 32'(e1_gi));
    chk("fp_lsu_gnt", 32'(lsu_gnt1), 32'(e1_gl));
    chk("fp_ifu_rvalid", 32'(ifu_rvalid1), 32'(m1_owner == 1));
    chk("fp_lsu_rvalid", 32'(lsu_rvalid1), 32'(m1_owner == 2));
    chk("fp_dbg_owner", 32'(dbg1), 32'(m1_owner));
    if (ir && !ifu_gnt0) ifu_wait++; else ifu_wait = 0;
    if (lr && !lsu_gnt0) lsu_wait++; else lsu_wait = 0;
    chk("ifu_starve", 32'(ifu_wait > 1), 32'h0);
    chk("lsu_starve", 32'(lsu_wait > 1), 32'h0);
    @(posedge clk); #1;
    if (m_owner == 1) m_ifu_hold = m_word;
    if (m_owner == 2) m_lsu_hold = m_word;
    m_owner = 0;
    if (e_gi) begin
      m_owner = 1; m_word = shadow[ia[9:2]]; m_rr_lsu = 1'b0;
    end else if (e_gl) begin
      m_rr_lsu = 1'b1;
      if (lw) begin
        for (int b = 0; b < 4; b++) if (lb[b]) shadow[la[9:2]][8*b +: 8] = ld[8*b +: 8];
      end else begin
        m_owner = 2; m_word = shadow[la[9:2]];
      end
    end
    m1_owner = e1_gi ? 1 : ((e1_gl && !lw) ? 2 : 0);
    last_gi = e_gi;
    last_gl = e_gl;
  endtask

  task automatic reset_cycles(input int n, input logic ir, input logic lr);
    rst = 1'b1;
    ifu_req = ir; lsu_req = lr; lsu_we = 1'b0;
    m_rr_lsu = 1'b1; m_owner = 0; m1_owner = 0;
    m_ifu_hold = '0; m_lsu_hold = '0;
    ifu_wait = 0; lsu_wait = 0;
    repeat (n) begin
      #3;
      chk("rst_ifu_gnt", 32'(ifu_gnt0), 32'h0);
      chk("rst_lsu_gnt", 32'(lsu_gnt0), 32'h0);
      chk("rst_mem_en", 32'(mem_en0), 32'h0);
      chk("rst_mem_we", 32'(mem_we0), 32'h0);
      chk("rst_ifu_rvalid", 32'(ifu_rvalid0), 32'h0);
      chk("rst_lsu_rvalid", 32'(lsu_rvalid0), 32'h0);
      chk("rst_ifu_rdata", ifu_rdata0, 32'h0);
      chk("rst_lsu_rdata", lsu_rdata0, 32'h0);
      chk("rst_fp_lsu_gnt", 32'(lsu_gnt1), 32'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic        ir_h, lr_h, lw_h;
    logic [31:0] ia_h, la_h, ld_h, hi_word;
    logic [3:0]  lb_h;

    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    ram_init = 1'b1;
    @(posedge clk); #1;
    ram_init = 1'b0;

    // Reset with both requests high
    reset_cycles(3, 1'b1, 1'b1);

    // IFU-only back-to-back fetches
    cycle(1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    cycle(1, 32'h4, 0, 0, 4'h0, 32'h0, 32'h0);
    cycle(1, 32'h8, 0, 0, 4'h0, 32'h0, 32'h0);
    cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("ifu_fetch_word2", ifu_rdata0, 32'h00000213);

    // Both held for 6 cycles from reset: round-robin alternates, fixed gives LSU
    reset_cycles(1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1, 32'h10, 1, 0, 4'h0, 32'h20, 32'h0);
    cycle(1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0);
    cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Partial write then read-back of the same word
    cycle(0, 32'h0, 1, 1, 4'b0011, 32'h100, 32'hDEADBEEF);
    cycle(0, 32'h0, 1, 0, 4'h0, 32'h100, 32'h0);
    cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    hi_word = init_word(64);
    chk("wr_rd_low", {16'h0, lsu_rdata0[15:0]}, 32'h0000BEEF);
    chk("wr_rd_high", {16'h0, lsu_rdata0[31:16]}, {16'h0, hi_word[31:16]});

    // Reset in the response cycle drops the rvalid; held request regranted afterwards
    cycle(1, 32'h8, 0, 0, 4'h0, 32'h0, 32'h0);
    reset_cycles(1, 1'b1, 1'b0);
    cycle(1, 32'h8, 0, 0, 4'h0, 32'h0, 32'h0);
    cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Random traffic; requesters hold their request until granted
    ir_h = 0; lr_h = 0; lw_h = 0; ia_h = '0; la_h = '0; ld_h = '0; lb_h = '0;
    for (int n = 0; n < 400; n++) begin
      if (!ir_h && $urandom_range(0, 3) != 0) begin
        ir_h = 1; ia_h = 32'($urandom_range(0, 15)) * 32'd4;
      end
      if (!lr_h && $urandom_range(0, 2) != 0) begin
        lr_h = 1; lw_h = 1'($urandom_range(0, 1));
        la_h = 32'($urandom_range(0, 15)) * 32'd4;
        ld_h = $urandom; lb_h = 4'($urandom_range(1, 15));
      end
      cycle(ir_h, ia_h, lr_h, lw_h, lb_h, la_h, ld_h);
      if (last_gi) ir_h = 0;
      if (last_gl) lr_h = 0;
    end
    cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
